// File: rtl/cond_flags_unit_pkg.sv
// Shared definitions for the NZCV flag register and ARM-style condition evaluation.
package cond_flags_unit_pkg;

  localparam int FLAGS_W = 4;

  // Bit positions inside the {n,z,c,v} vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Result stage occupancy; the encoding doubles as r_valid.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } res_state_e;

endpackage

// File: rtl/cond_flags_unit_eval.sv
// Combinational condition-code evaluator; reusable wherever a cond field meets NZCV.
module cond_eval
  import cond_flags_unit_pkg::*;
(
  input  logic [3:0]         cond_i,
  input  logic [FLAGS_W-1:0] flags_i,
  output logic               taken_o
);

  logic n, z, c, v;

  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    taken_o = 1'b0;
    case (cond_i)
      COND_EQ: taken_o = z;
      COND_NE: taken_o = ~z;
      COND_CS: taken_o = c;
      COND_CC: taken_o = ~c;
      COND_MI: taken_o = n;
      COND_PL: taken_o = ~n;
      COND_VS: taken_o = v;
      COND_VC: taken_o = ~v;
      COND_HI: taken_o = c & ~z;
      COND_LS: taken_o = ~c | z;
      COND_GE: taken_o = (n == v);
      COND_LT: taken_o = (n != v);
      COND_GT: taken_o = ~z & (n == v);
      COND_LE: taken_o = z | (n != v);
      COND_AL: taken_o = 1'b1;
      COND_NV: taken_o = 1'b1;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_flags_unit.sv
// NZCV status register with masked updates and a single-entry registered condition-query stage.
module cond_flags_unit
  import cond_flags_unit_pkg::*;
#(
  parameter bit                 BYPASS    = 1'b1,
  parameter logic [FLAGS_W-1:0] FLAGS_RST = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               upd_valid,
  input  logic [FLAGS_W-1:0] upd_mask,
  input  logic               n_in,
  input  logic               z_in,
  input  logic               c_in,
  input  logic               v_in,
  input  logic               q_valid,
  output logic               q_ready,
  input  logic [3:0]         q_cond,
  output logic               r_valid,
  input  logic               r_ready,
  output logic               r_taken,
  output logic [3:0]         r_cond,
  output logic [FLAGS_W-1:0] flags
);

  logic [FLAGS_W-1:0] flags_q, flags_d;
  logic [FLAGS_W-1:0] upd_bits, merged, eff_flags;
  res_state_e         state_q, state_d;
  logic               r_taken_q, r_taken_d;
  logic [3:0]         r_cond_q, r_cond_d;
  logic               accept, eval_taken;

  assign upd_bits = {n_in, z_in, c_in, v_in};
  assign merged   = (flags_q & ~upd_mask) | (upd_bits & upd_mask);
  assign flags_d  = upd_valid ? merged : flags_q;

  // With bypass, a query sees the flags that this cycle's update is about to write.
  assign eff_flags = (BYPASS && upd_valid) ? merged : flags_q;

  cond_eval u_eval (
    .cond_i  (q_cond),
    .flags_i (eff_flags),
    .taken_o (eval_taken)
  );

  assign q_ready = (state_q == ST_EMPTY) | r_ready;
  assign accept  = q_valid & q_ready;

  always_comb begin
    state_d   = state_q;
    r_taken_d = r_taken_q;
    r_cond_d  = r_cond_q;
    if (accept) begin
      state_d   = ST_FULL;
      r_taken_d = eval_taken;
      r_cond_d  = q_cond;
    end else if (r_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q   <= FLAGS_RST;
      state_q   <= ST_EMPTY;
      r_taken_q <= 1'b0;
      r_cond_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      flags_q   <= flags_d;
      state_q   <= state_d;
      r_taken_q <= r_taken_d;
      r_cond_q  <= r_cond_d;
    end
  end

  assign r_valid = (state_q == ST_FULL);
  assign r_taken = r_taken_q;
  assign r_cond  = r_cond_q;
  assign flags   = flags_q;

endmodule

// File: tb/tb_cond_flags_unit.sv
// Drives a BYPASS=1 and a BYPASS=0 instance in lockstep against a behavioural flag/query model.
module tb_cond_flags_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       upd_valid = 1'b0;
  logic [3:0] upd_mask = 4'b0000;
  logic       n_in = 1'b0, z_in = 1'b0, c_in = 1'b0, v_in = 1'b0;
  logic       q_valid = 1'b0;
  logic [3:0] q_cond = 4'b0000;
  logic       r_ready = 1'b0;

  logic       q_ready1, r_valid1, r_taken1, q_ready0, r_valid0, r_taken0;
  logic [3:0] r_cond1, flags1, r_cond0, flags0;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  logic [3:0] m_flags = 4'b0000;
  bit         m_valid = 1'b0;
  logic [3:0] m_cond  = 4'b0000;
  bit         m_taken1 = 1'b0, m_taken0 = 1'b0;

  always #5 clk = ~clk;

  cond_flags_unit #(.BYPASS(1'b1), .FLAGS_RST(4'b0000)) u_byp1 (
    .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_mask(upd_mask),
    .n_in(n_in), .z_in(z_in), .c_in(c_in), .v_in(v_in),
    .q_valid(q_valid), .q_ready(q_ready1), .q_cond(q_cond),
    .r_valid(r_valid1), .r_ready(r_ready), .r_taken(r_taken1), .r_cond(r_cond1),
    .flags(flags1)
  );

  cond_flags_unit #(.BYPASS(1'b0), .FLAGS_RST(4'b0000)) u_byp0 (
    .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_mask(upd_mask),
    .n_in(n_in), .z_in(z_in), .c_in(c_in), .v_in(v_in),
    .q_valid(q_valid), .q_ready(q_ready0), .q_cond(q_cond),
    .r_valid(r_valid0), .r_ready(r_ready), .r_taken(r_taken0), .r_cond(r_cond0),
    .flags(flags0)
  );

  // ARM condition semantics written straight from the mnemonic table.
  function automatic bit ref_eval(input logic [3:0] cond, input logic [3:0] f);
    bit n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cond)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  // 32-bit compare: flags of a - b with C meaning "no borrow".
  function automatic logic [3:0] cmp_flags(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    d = a - b;
    return {d[31], d == 32'd0, a >= b, (a[31] != b[31]) && (d[31] != a[31])};
  endfunction

  task automatic drive(input bit uv, input logic [3:0] mask, input logic [3:0] nzcv,
                       input bit qv, input logic [3:0] qc, input bit rr);
    upd_valid = uv; upd_mask = mask;
    {n_in, z_in, c_in, v_in} = nzcv;
    q_valid = qv; q_cond = qc; r_ready = rr;
  endtask

  // Advance one clock, then settle the model to what the next edge should have produced.
  task automatic tick();
    logic [3:0] merged;
    bit acc;
    merged = (m_flags & ~upd_mask) | ({n_in, z_in, c_in, v_in} & upd_mask);
    acc = q_valid && (!m_valid || r_ready);
    @(posedge clk);
    #1;
    if (acc) begin
      m_valid  = 1'b1;
      m_cond   = q_cond;
      m_taken1 = ref_eval(q_cond, upd_valid ? merged : m_flags);
      m_taken0 = ref_eval(q_cond, m_flags);
    end else if (r_ready) begin
      m_valid = 1'b0;
    end
    if (upd_valid) m_flags = merged;
  endtask

  task automatic model_reset();
    m_flags = 4'b0000; m_valid = 1'b0; m_cond = 4'b0000;
    m_taken1 = 1'b0; m_taken0 = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if ({flags1, flags0} !== 8'h00) begin
      n_err++; $display("FAIL reset_flags: got %b/%b expected 0000", flags1, flags0);
    end
    n_vec++;
    if ({r_valid1, r_valid0, r_taken1, r_taken0, r_cond1, r_cond0} !== 12'h000) begin
      n_err++; $display("FAIL reset_result: got v=%b%b t=%b%b c=%b/%b expected zeros",
                        r_valid1, r_valid0, r_taken1, r_taken0, r_cond1, r_cond0);
    end
    n_vec++;
    if ({q_ready1, q_ready0} !== 2'b11) begin
      n_err++; $display("FAIL reset_q_ready: got %b%b expected 11", q_ready1, q_ready0);
    end
    #5 rst_n = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic run_queries(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] exp_f, input logic [15:0] conds,
                             input logic [3:0] exps);
    drive(1'b1, 4'b1111, cmp_flags(a, b), 1'b0, 4'b0000, 1'b1);
    tick();
    drive(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1);
    n_vec++;
    if ({flags1, flags0} !== {exp_f, exp_f}) begin
      n_err++; $display("FAIL %s_flags: got %b/%b expected %b", tag, flags1, flags0, exp_f);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'b0000, 4'b0000, 1'b1, conds[15-4*i -: 4], 1'b1);
      tick();
      n_vec++;
      if ({r_valid1, r_taken1, r_cond1} !== {1'b1, exps[3-i], conds[15-4*i -: 4]} ||
          {r_valid0, r_taken0, r_cond0} !== {1'b1, exps[3-i], conds[15-4*i -: 4]}) begin
        n_err++;
        $display("FAIL %s_q%0d: got v%b t%b c%b / v%b t%b c%b expected v1 t%b c%b", tag, i,
                 r_valid1, r_taken1, r_cond1, r_valid0, r_taken0, r_cond0,
                 exps[3-i], conds[15-4*i -: 4]);
      end
    end
    drive(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1);
    tick();
  endtask

  task automatic test_cmp();
    // 5-5: n0 z1 c1 v0; EQ NE HI LS -> 1 0 0 1
    run_queries("cmp_eq", 32'd5, 32'd5, 4'b0110, {4'd0, 4'd1, 4'd8, 4'd9}, 4'b1001);
    // 0x80000000-1: n0 z0 c1 v1; LT GE GT CS -> 1 0 0 1
    run_queries("cmp_ovf", 32'h8000_0000, 32'd1, 4'b0011, {4'd11, 4'd10, 4'd12, 4'd2}, 4'b1001);
  endtask

  task automatic test_bypass();
    drive(1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b1);
    tick();
    drive(1'b1, 4'b1111, 4'b0100, 1'b1, 4'd0, 1'b1);
    tick();
    n_vec++;
    if ({r_valid1, r_taken1, r_valid0, r_taken0} !== 4'b1110) begin
      n_err++; $display("FAIL bypass_taken: got byp1 v%b t%b byp0 v%b t%b expected 1 1 / 1 0",
                        r_valid1, r_taken1, r_valid0, r_taken0);
    end
    n_vec++;
    if ({flags1, flags0} !== 8'b0100_0100) begin
      n_err++; $display("FAIL bypass_flags: got %b/%b expected 0100", flags1, flags0);
    end
    drive(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1);
    tick();
  endtask

  task automatic test_mask();
    drive(1'b1, 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b1);
    tick();
    drive(1'b1, 4'b1100, 4'b0000, 1'b0, 4'b0000, 1'b1);
    tick();
    n_vec++;
    if ({flags1, flags0} !== 8'b0011_0011) begin
      n_err++; $display("FAIL mask_flags: got %b/%b expected 0011", flags1, flags0);
    end
    drive(1'b0, 4'b0000, 4'b0000, 1'b1, 4'd6, 1'b1);
    tick();
    n_vec++;
    if ({r_valid1, r_taken1, r_valid0, r_taken0} !== 4'b1111) begin
      n_err++; $display("FAIL mask_vs: got v%b t%b / v%b t%b expected all 1",
                        r_valid1, r_taken1, r_valid0, r_taken0);
    end
    drive(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1);
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] c;
    // flags are 0011 here, so EQ evaluates false
    drive(1'b0, 4'b0000, 4'b0000, 1'b1, 4'd0, 1'b0);
    tick();
    drive(1'b1, 4'b1111, 4'b1111, 1'b1, 4'd1, 1'b0);
    #1;
    n_vec++;
    if ({q_ready1, q_ready0} !== 2'b00) begin
      n_err++; $display("FAIL bp_stall: got q_ready %b%b expected 00", q_ready1, q_ready0);
    end
    tick();
    n_vec++;
    if ({r_valid1, r_taken1, r_cond1, r_valid0, r_taken0, r_cond0} !== 12'b10_0000_10_0000 ||
        {flags1, flags0} !== 8'hFF) begin
      n_err++; $display("FAIL bp_hold: got v%b t%b c%b flags %b/%b expected v1 t0 c0000 flags 1111",
                        r_valid1, r_taken1, r_cond1, flags1, flags0);
    end
    drive(1'b0, 4'b0000, 4'b0000, 1'b1, 4'd1, 1'b1);
    #1;
    n_vec++;
    if ({q_ready1, q_ready0} !== 2'b11) begin
      n_err++; $display("FAIL bp_release: got q_ready %b%b expected 11", q_ready1, q_ready0);
    end
    tick();
    n_vec++;
    if ({r_valid1, r_taken1, r_cond1, r_valid0, r_taken0, r_cond0} !== 12'b10_0001_10_0001) begin
      n_err++; $display("FAIL bp_ne: got v%b t%b c%b expected v1 t0 c0001", r_valid1, r_taken1, r_cond1);
    end
    for (int i = 0; i < 8; i++) begin
      c = 4'($urandom_range(0, 15));
      drive(1'b0, 4'b0000, 4'b0000, 1'b1, c, 1'b1);
      tick();
      n_vec++;
      if (r_valid1 !== 1'b1 || r_cond1 !== c || r_taken1 !== ref_eval(c, 4'b1111) ||
          r_valid0 !== 1'b1 || r_cond0 !== c || r_taken0 !== ref_eval(c, 4'b1111)) begin
        n_err++; $display("FAIL b2b_%0d: got v%b c%b t%b / v%b c%b t%b expected c%b", i,
                          r_valid1, r_cond1, r_taken1, r_valid0, r_cond0, r_taken0, c);
      end
    end
    drive(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1);
    tick();
    n_vec++;
    if ({r_valid1, r_valid0} !== 2'b00) begin
      n_err++; $display("FAIL b2b_drain: got r_valid %b%b expected 00", r_valid1, r_valid0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom_range(0, 3) != 0),
            4'($urandom), 1'($urandom_range(0, 3) != 0));
      #1;
      n_vec++;
      if (q_ready1 !== (!m_valid || r_ready) || q_ready0 !== (!m_valid || r_ready)) begin
        n_err++; $display("FAIL rnd_q_ready_%0d: got %b%b expected %b", i, q_ready1, q_ready0,
                          !m_valid || r_ready);
      end
      tick();
      n_vec++;
      if (flags1 !== m_flags || flags0 !== m_flags || r_valid1 !== m_valid || r_valid0 !== m_valid ||
          (m_valid && (r_cond1 !== m_cond || r_cond0 !== m_cond ||
                       r_taken1 !== m_taken1 || r_taken0 !== m_taken0))) begin
        n_err++;
        $display("FAIL rnd_%0d: got f%b/%b v%b%b c%b/%b t%b%b expected f%b v%b c%b t%b%b", i,
                 flags1, flags0, r_valid1, r_valid0, r_cond1, r_cond0, r_taken1, r_taken0,
                 m_flags, m_valid, m_cond, m_taken1, m_taken0);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 4'b1111, 4'b1010, 1'b1, 4'd14, 1'b0);
    tick();
    drive(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
    n_vec++;
    if ({r_valid1, r_valid0} !== 2'b11 || {flags1, flags0} !== 8'b1010_1010) begin
      n_err++; $display("FAIL rstmid_pre: got v%b%b flags %b/%b expected v11 flags 1010",
                        r_valid1, r_valid0, flags1, flags0);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({r_valid1, r_valid0} !== 2'b00 || {flags1, flags0} !== 8'h00) begin
      n_err++; $display("FAIL rstmid_async: got v%b%b flags %b/%b expected v00 flags 0000",
                        r_valid1, r_valid0, flags1, flags0);
    end
    model_reset();
    #1 rst_n = 1'b1;
    #1;
    n_vec++;
    if ({q_ready1, q_ready0} !== 2'b11) begin
      n_err++; $display("FAIL rstmid_q_ready: got %b%b expected 11", q_ready1, q_ready0);
    end
    tick();
    n_vec++;
    if ({r_valid1, r_valid0} !== 2'b00 || {flags1, flags0} !== 8'h00) begin
      n_err++; $display("FAIL rstmid_post: got v%b%b flags %b/%b expected v00 flags 0000",
                        r_valid1, r_valid0, flags1, flags0);
    end
  endtask

  initial begin
    test_reset();
    test_cmp();
    test_bypass();
    test_mask();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
